// File: rtl/muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// muldiv_seq_if
// Handshake and operand bundle between the CPU control unit and the
// multi-cycle multiply/divide sequencer.
//
//   start  : launch request (CPU -> sequencer)
//   op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU, sampled with start
//   a, b   : Rs / Rt operands, sampled with start
//   flush  : abort from the exception path
//   busy   : operation in progress, CPU stalls (sequencer -> CPU)
//   done   : one-cycle pulse, hi/lo carry the new result
//   hi, lo : product high/low words, or remainder/quotient
//
// Modports: master = CPU side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Iterative sequencer for MULT/MULTU/DIV/DIVU feeding the HI/LO registers.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle for
// WIDTH cycles, then one sign-correction cycle, then a one-cycle done pulse.
// Signed operations run on magnitudes; the signs are applied in FIX.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : muldiv_seq_if.slave (start/op/a/b/flush in, busy/done/hi/lo out)
//
// Optional feature macro: MULDIV_EARLY_TERM_EN
//   When defined, multiplies leave CALC as soon as the remaining multiplier
//   bits are all zero. Divides always take the full WIDTH steps.
// -----------------------------------------------------------------------------
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   muldiv_seq_if.slave  bus
);

   localparam int                 CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
   localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]     ZERO_R   = {(WIDTH+1){1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Two's-complement negate of a WIDTH-bit word.
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      neg_w = (~x) + ONE_W;
   endfunction

   // Two's-complement negate of a 2*WIDTH-bit word.
   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
      neg_2w = (~x) + ONE_2W;
   endfunction

   // Magnitude of a signed WIDTH-bit word (0x80..0 maps to itself, which is
   // the correct unsigned magnitude).
   function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
      abs_w = x[WIDTH-1] ? neg_w(x) : x;
   endfunction

   state_t             state_r;
   state_t             fsm_next_s;
   state_t             state_next_s;
   logic               launch_s;
   logic               last_step_s;
   logic [CNT_W-1:0]   cnt_r;

   logic               is_div_r;
   logic               sa_r;
   logic               sb_r;
   logic               dz_r;
   logic [WIDTH-1:0]   a_raw_r;

   // multiply datapath
   logic [2*WIDTH-1:0] acc_r;
   logic [2*WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [2*WIDTH-1:0] acc_step_s;

   // divide datapath; rem_r carries one extra bit for the trial subtract
   logic [WIDTH:0]     rem_r;
   logic [WIDTH-1:0]   quot_r;
   logic [WIDTH-1:0]   divisor_r;
   logic [WIDTH+1:0]   rem_sh_s;
   logic [WIDTH+1:0]   sub_s;

   logic               op_signed_s;
   logic [WIDTH-1:0]   a_mag_s;
   logic [WIDTH-1:0]   b_mag_s;

   logic [2*WIDTH-1:0] prod_fix_s;
   logic [WIDTH-1:0]   quot_fix_s;
   logic [WIDTH-1:0]   rem_fix_s;
   logic [WIDTH-1:0]   hi_res_s;
   logic [WIDTH-1:0]   lo_res_s;

   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               busy_r;
   logic               done_r;

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

   // Operand capture: signed ops work on magnitudes, op[0]=1 means unsigned.
   always_comb begin
      op_signed_s = ~bus.op[0];
      if (op_signed_s) begin
         a_mag_s = abs_w(bus.a);
         b_mag_s = abs_w(bus.b);
      end else begin
         a_mag_s = bus.a;
         b_mag_s = bus.b;
      end
   end

   // Last CALC step detection (optionally cut short for small multipliers).
   always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
      // mplier_r[WIDTH-1:1] is the multiplier left after this step's shift.
      last_step_s = (cnt_r == CNT_LAST) ||
                    (!is_div_r && (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}}));
`else
      last_step_s = (cnt_r == CNT_LAST);
`endif
   end

   // Next-state logic; flush overrides every transition and suppresses launch.
   always_comb begin
      fsm_next_s = state_r;
      launch_s   = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               fsm_next_s = ST_CALC;
               launch_s   = 1'b1;
            end else begin
               fsm_next_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (last_step_s) begin
               fsm_next_s = ST_FIX;
            end else begin
               fsm_next_s = ST_CALC;
            end
         end
         ST_FIX: begin
            fsm_next_s = ST_DONE;
         end
         default: begin
            fsm_next_s = ST_IDLE;
         end
      endcase
      if (bus.flush) begin
         state_next_s = ST_IDLE;
         launch_s     = 1'b0;
      end else begin
         state_next_s = fsm_next_s;
      end
   end

   // State register plus registered busy/done derived from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s == ST_CALC) || (state_next_s == ST_FIX);
         done_r  <= (state_next_s == ST_DONE);
      end
   end

   // Single-step arithmetic for both engines.
   always_comb begin
      if (mplier_r[0]) begin
         acc_step_s = acc_r + mcand_r;
      end else begin
         acc_step_s = acc_r;
      end
      // Bring down the next dividend bit, then try subtracting the divisor;
      // a set MSB of the difference means the trial went negative.
      rem_sh_s = {rem_r, quot_r[WIDTH-1]};
      sub_s    = rem_sh_s - {2'b00, divisor_r};
   end

   // Datapath registers: load on launch, step while in CALC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r     <= CNT_ZERO;
         is_div_r  <= 1'b0;
         sa_r      <= 1'b0;
         sb_r      <= 1'b0;
         dz_r      <= 1'b0;
         a_raw_r   <= ZERO_W;
         acc_r     <= ZERO_2W;
         mcand_r   <= ZERO_2W;
         mplier_r  <= ZERO_W;
         rem_r     <= ZERO_R;
         quot_r    <= ZERO_W;
         divisor_r <= ZERO_W;
      end else if (launch_s) begin
         cnt_r     <= CNT_ZERO;
         is_div_r  <= bus.op[1];
         sa_r      <= op_signed_s & bus.a[WIDTH-1];
         sb_r      <= op_signed_s & bus.b[WIDTH-1];
         dz_r      <= bus.op[1] & (bus.b == ZERO_W);
         a_raw_r   <= bus.a;
         acc_r     <= ZERO_2W;
         mcand_r   <= {ZERO_W, a_mag_s};
         mplier_r  <= b_mag_s;
         rem_r     <= ZERO_R;
         quot_r    <= a_mag_s;
         divisor_r <= b_mag_s;
      end else if ((state_r == ST_CALC) && !bus.flush) begin
         cnt_r <= cnt_r + CNT_ONE;
         if (is_div_r) begin
            if (sub_s[WIDTH+1]) begin
               rem_r  <= rem_sh_s[WIDTH:0];
               quot_r <= {quot_r[WIDTH-2:0], 1'b0};
            end else begin
               rem_r  <= sub_s[WIDTH:0];
               quot_r <= {quot_r[WIDTH-2:0], 1'b1};
            end
         end else begin
            acc_r    <= acc_step_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
         end
      end
   end

   // Sign correction and divide-by-zero override, consumed in FIX.
   always_comb begin
      if (sa_r ^ sb_r) begin
         prod_fix_s = neg_2w(acc_r);
         quot_fix_s = neg_w(quot_r);
      end else begin
         prod_fix_s = acc_r;
         quot_fix_s = quot_r;
      end
      // Remainder takes the sign of the dividend.
      if (sa_r) begin
         rem_fix_s = neg_w(rem_r[WIDTH-1:0]);
      end else begin
         rem_fix_s = rem_r[WIDTH-1:0];
      end
      if (!is_div_r) begin
         hi_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
         lo_res_s = prod_fix_s[WIDTH-1:0];
      end else if (dz_r) begin
         hi_res_s = a_raw_r;
         lo_res_s = ONES_W;
      end else begin
         hi_res_s = rem_fix_s;
         lo_res_s = quot_fix_s;
      end
   end

   // Result registers: written only on the FIX->DONE edge, held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_r <= ZERO_W;
         lo_r <= ZERO_W;
      end else if ((state_r == ST_FIX) && !bus.flush) begin
         hi_r <= hi_res_s;
         lo_r <= lo_res_s;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Directed bench for muldiv_seq. A transaction-level model (plain SV
// arithmetic plus a busy-cycle countdown) predicts busy/done/hi/lo and is
// compared against the DUT on every falling edge; directed runs additionally
// pin results and latencies with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

`ifdef MULDIV_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   muldiv_seq_if #(.WIDTH(32)) bus ();

   muldiv_seq #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference result {hi, lo} from plain arithmetic.
   function automatic logic [63:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin q = sa * sb; p = q; end
         2'b01: p = {32'h0, a} * {32'h0, b};
         default: begin
            if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
            else if (op == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   // Cycles from start to done.
   function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
      logic [31:0] mag;
      int k;
      mag = (op == 2'b00 && b[31]) ? (~b + 32'd1) : b;
      k = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
      return (EARLY && !op[1]) ? k + 2 : 34;
   endfunction

   // Behavioural model state.
   int          m_cnt;
   logic        e_busy, e_done;
   logic [31:0] e_hi, e_lo;
   logic [63:0] pend;

   // Model: accept start when idle, count down busy cycles, then pulse done.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt <= 0; e_busy <= 1'b0; e_done <= 1'b0; e_hi <= 32'h0; e_lo <= 32'h0;
         pend <= 64'h0;
      end else if (bus.flush) begin
         m_cnt <= 0; e_busy <= 1'b0; e_done <= 1'b0;
      end else if (!e_busy) begin
         e_done <= 1'b0;
         if (bus.start) begin
            m_cnt  <= model_lat(bus.op, bus.b) - 1;
            pend   <= model_res(bus.op, bus.a, bus.b);
            e_busy <= 1'b1;
         end
      end else if (m_cnt == 1) begin
         m_cnt <= 0; e_busy <= 1'b0; e_done <= 1'b1;
         e_hi <= pend[63:32]; e_lo <= pend[31:0];
      end else begin
         m_cnt <= m_cnt - 1;
      end
   end

   // Compare process: every cycle out of reset.
   always @(negedge clk) begin
      if (!rst) begin
         check("busy", {63'h0, bus.busy}, {63'h0, e_busy});
         check("done", {63'h0, bus.done}, {63'h0, e_done});
         check("hi", {32'h0, bus.hi}, {32'h0, e_hi});
         check("lo", {32'h0, bus.lo}, {32'h0, e_lo});
      end
   end

   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int c0);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      c0 = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int c0, input int lat);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (bus.done) break;
      end
      check({nm, " latency"}, 64'(cyc - c0), 64'(lat));
   endtask

   task automatic run(input string nm, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] xhi, input logic [31:0] xlo,
                      input int lat);
      int c0;
      launch(op, a, b, c0);
      check({nm, " busy@1"}, {63'h0, bus.busy}, 64'h1);
      wait_done(nm, c0, lat);
      check({nm, " hi"}, {32'h0, bus.hi}, {32'h0, xhi});
      check({nm, " lo"}, {32'h0, bus.lo}, {32'h0, xlo});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1;
      rst = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'h0; bus.b = 32'h0; bus.flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", {63'h0, bus.busy}, 64'h0);
      check("reset done", {63'h0, bus.done}, 64'h0);
      check("reset hi", {32'h0, bus.hi}, 64'h0);
      check("reset lo", {32'h0, bus.lo}, 64'h0);
      rst = 1'b0;

      run("MULTU max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34);
      run("MULT -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, EARLY ? 5 : 34);
      run("MULT -2*-3", 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'd6, EARLY ? 4 : 34);
      run("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
      run("DIV ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);
      run("DIVU by0", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 34);
      run("DIV by0", 2'b10, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 34);
      run("MULTU 5x3", 2'b01, 32'd5, 32'd3, 32'h0, 32'h0000_000F, EARLY ? 4 : 34);
      run("MULTU 5x0", 2'b01, 32'd5, 32'd0, 32'h0, 32'h0, EARLY ? 3 : 34);
      run("DIVU 1000/7", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 34);

      // Flush in cycle 10, restart in cycle 11.
      launch(2'b11, 32'hFFFF_FFFF, 32'd3, c0);
      repeat (9) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'hFFFF_FFFF; bus.b = 32'd3;
      @(negedge clk);
      check("flush busy@11", {63'h0, bus.busy}, 64'h0);
      check("flush kept hi", {32'h0, bus.hi}, 64'd6);
      check("flush kept lo", {32'h0, bus.lo}, 64'd142);
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done("post-flush", c0, 45);
      check("post-flush lo", {32'h0, bus.lo}, 64'h5555_5555);
      check("post-flush hi", {32'h0, bus.hi}, 64'h0);

      // start together with flush while idle is ignored.
      @(posedge clk); #1;
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd2;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      @(negedge clk);
      check("start+flush busy", {63'h0, bus.busy}, 64'h0);
      repeat (3) @(posedge clk);

      // Back-to-back: start in the DONE cycle; a start while busy is ignored.
      launch(2'b01, 32'd6, 32'd7, c0);
      wait_done("b2b first", c0, EARLY ? 5 : 34);
      check("b2b first lo", {32'h0, bus.lo}, 64'd42);
      bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd45; bus.b = 32'd6;
      c1 = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("b2b busy next", {63'h0, bus.busy}, 64'h1);
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd9; bus.b = 32'd9;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done("b2b second", c1, 34);
      check("b2b second lo", {32'h0, bus.lo}, 64'd7);
      check("b2b second hi", {32'h0, bus.hi}, 64'd3);

      // Asynchronous reset mid-operation.
      launch(2'b11, 32'd77, 32'd5, c0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst busy", {63'h0, bus.busy}, 64'h0);
      check("rst hi", {32'h0, bus.hi}, 64'h0);
      check("rst lo", {32'h0, bus.lo}, 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
